// File: rtl/sat_mon_pkg.sv
// ============================================================================
// sat_mon_pkg : shared state encoding and sizing for the saturation monitor
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sat_mon_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OVL  = 1'b1
   } state_t;

   localparam int HCNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/sat_mon_if.sv
// ============================================================================
// sat_mon_if : sample stream in, clip/overload status out
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface sat_mon_if #(
   parameter int DSZ = 12,
   parameter int WSZ = 10
);
   logic signed [DSZ-1:0] in;
   logic                  valid;
   logic                  clr;
   logic                  clip;
   logic                  sticky;
   logic                  ovl;
   logic [WSZ:0]          clip_cnt;
   logic [DSZ-2:0]        peak;
   logic                  peak_stb;

   modport master (
      output in, valid, clr,
      input  clip, sticky, ovl, clip_cnt, peak, peak_stb
   );

   modport slave (
      input  in, valid, clr,
      output clip, sticky, ovl, clip_cnt, peak, peak_stb
   );
endinterface

`default_nettype wire

// File: rtl/sat_abs.sv
// ============================================================================
// sat_abs : combinational saturating magnitude, DSZ signed -> DSZ-1 unsigned
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_abs #(
   parameter int DSZ = 12
) (
   input  logic [DSZ-1:0] x_i,
   output logic [DSZ-2:0] mag_o
);
   localparam logic [DSZ-1:0] MAXNEG = {1'b1, {(DSZ-1){1'b0}}};

   logic [DSZ-1:0] neg;

   always_comb begin
      neg = {DSZ{1'b0}} - x_i;
      // the most negative code has no positive twin; clamp it to full scale
      if (x_i == MAXNEG) begin
         mag_o = {(DSZ-1){1'b1}};
      end else if (x_i[DSZ-1]) begin
         mag_o = neg[DSZ-2:0];
      end else begin
         mag_o = x_i[DSZ-2:0];
      end
   end
endmodule

`default_nettype wire

// File: rtl/sat_mon.sv
// ============================================================================
// sat_mon : clip detector, windowed clip counter / peak tracker, held overload
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_mon
   import sat_mon_pkg::*;
#(
   parameter int DSZ    = 12,
   parameter int WSZ    = 10,
   parameter int THRESH = 4,
   parameter int HOLD   = 2
) (
   input  logic       clk,
   input  logic       reset,
   sat_mon_if.slave   bus
);
   localparam logic [DSZ-1:0]    MAXPOS = {1'b0, {(DSZ-1){1'b1}}};
   localparam logic [DSZ-1:0]    MAXNEG = {1'b1, {(DSZ-1){1'b0}}};
   localparam logic [WSZ:0]      THR    = THRESH[WSZ:0];
   localparam logic [HCNT_W-1:0] HLD    = HOLD[HCNT_W-1:0];

   logic [WSZ-1:0]    wcnt_q;
   logic [WSZ:0]      ccnt_q;
   logic [DSZ-2:0]    pk_q;
   logic              clip_q, sticky_q, sticky_d, stb_q;
   logic [WSZ:0]      clip_cnt_q;
   logic [DSZ-2:0]    peak_q;
   state_t            state_q, state_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;

   logic              clip_det, win_end, hit;
   logic [DSZ-2:0]    mag, pk_new;
   logic [WSZ:0]      ccnt_tot;

   sat_abs #(.DSZ(DSZ)) u_abs (
      .x_i   (bus.in),
      .mag_o (mag)
   );

   assign clip_det = (bus.in == MAXPOS) || (bus.in == MAXNEG);
   assign win_end  = bus.valid && (wcnt_q == {WSZ{1'b1}});
   assign ccnt_tot = ccnt_q + {{WSZ{1'b0}}, clip_det};
   assign pk_new   = (mag > pk_q) ? mag : pk_q;
   assign hit      = (ccnt_tot >= THR);
   // a clip pulse in the same cycle as clr must not be lost
   assign sticky_d = clip_q ? 1'b1 : (bus.clr ? 1'b0 : sticky_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q     <= '0;
         ccnt_q     <= '0;
         pk_q       <= '0;
         clip_q     <= 1'b0;
         sticky_q   <= 1'b0;
         stb_q      <= 1'b0;
         clip_cnt_q <= '0;
         peak_q     <= '0;
      end else begin
         clip_q   <= bus.valid & clip_det;
         sticky_q <= sticky_d;
         stb_q    <= win_end;
         if (bus.valid) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (win_end) begin
               clip_cnt_q <= ccnt_tot;
               peak_q     <= pk_new;
               ccnt_q     <= '0;
               pk_q       <= '0;
            end else begin
               ccnt_q <= ccnt_tot;
               pk_q   <= pk_new;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      if (win_end) begin
         case (state_q)
            ST_IDLE: begin
               if (hit) begin
                  state_d = ST_OVL;
                  hcnt_d  = HLD;
               end
            end
            ST_OVL: begin
               if (hit) begin
                  hcnt_d = HLD;
               end else if (hcnt_q == {{(HCNT_W-1){1'b0}}, 1'b1}) begin
                  state_d = ST_IDLE;
                  hcnt_d  = '0;
               end else begin
                  hcnt_d = hcnt_q - 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               hcnt_d  = '0;
            end
         endcase
      end
   end

   assign bus.clip     = clip_q;
   assign bus.sticky   = sticky_q;
   assign bus.ovl      = (state_q == ST_OVL);
   assign bus.clip_cnt = clip_cnt_q;
   assign bus.peak     = peak_q;
   assign bus.peak_stb = stb_q;
endmodule

`default_nettype wire

// File: tb/tb_sat_mon.sv
// ============================================================================
// tb_sat_mon : directed and randomized stimulus against a window-level model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_sat_mon;
   localparam int DSZ = 12;
   localparam int WSZ = 4;
   localparam int WIN = 16;
   localparam int THR = 4;
   localparam int HLD = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sat_mon_if #(.DSZ(DSZ), .WSZ(WSZ)) bus ();

   sat_mon #(.DSZ(DSZ), .WSZ(WSZ), .THRESH(THR), .HOLD(HLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model: samples of the open window, plus expected registered outputs
   int win_q[$];
   bit m_clip, m_sticky, m_ovl, m_stb;
   int m_hold, m_cnt, m_peak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit fs(input int x);
      return (x == 2047) || (x == -2048);
   endfunction

   function automatic int mag(input int x);
      if (x == -2048) return 2047;
      return (x < 0) ? -x : x;
   endfunction

   function automatic int rnd_nc();
      return int'($urandom_range(0, 4092)) - 2046;
   endfunction

   function automatic int rnd_fs();
      return ($urandom_range(0, 1) == 1) ? 2047 : -2048;
   endfunction

   task automatic model_reset();
      win_q.delete();
      m_clip = 0; m_sticky = 0; m_ovl = 0; m_stb = 0;
      m_hold = 0; m_cnt = 0; m_peak = 0;
   endtask

   task automatic close_window();
      m_cnt  = 0;
      m_peak = 0;
      foreach (win_q[i]) begin
         if (fs(win_q[i])) m_cnt++;
         if (mag(win_q[i]) > m_peak) m_peak = mag(win_q[i]);
      end
      m_stb = 1;
      if (m_cnt >= THR) begin
         m_ovl  = 1;
         m_hold = HLD;
      end else if (m_ovl) begin
         m_hold--;
         if (m_hold == 0) m_ovl = 0;
      end
      win_q.delete();
   endtask

   task automatic step(input bit v, input int x, input bit c, input bit r);
      @(negedge clk);
      reset     = r;
      bus.valid = v;
      bus.in    = x[DSZ-1:0];
      bus.clr   = c;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         m_sticky = m_clip ? 1'b1 : (c ? 1'b0 : m_sticky);
         m_clip   = v && fs(x);
         m_stb    = 0;
         if (v) begin
            win_q.push_back(x);
            if (win_q.size() == WIN) close_window();
         end
      end
      #1;
      chk("clip",     32'(bus.clip),     32'(m_clip));
      chk("sticky",   32'(bus.sticky),   32'(m_sticky));
      chk("ovl",      32'(bus.ovl),      32'(m_ovl));
      chk("peak_stb", 32'(bus.peak_stb), 32'(m_stb));
      chk("clip_cnt", 32'(bus.clip_cnt), 32'(m_cnt));
      chk("peak",     32'(bus.peak),     32'(m_peak));
   endtask

   initial begin
      int pulses, stbs, x;
      reset     = 1'b1;
      bus.valid = 1'b0;
      bus.in    = '0;
      bus.clr   = 1'b0;
      model_reset();

      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      // 1: quiet window
      for (int i = 0; i < WIN; i++) step(1, 100, 0, 0);
      chk("t1_peak", 32'(bus.peak), 100);
      chk("t1_stb",  32'(bus.peak_stb), 1);

      // 2: four full-scale samples trip overload
      pulses = 0;
      for (int i = 0; i < WIN; i++) begin
         if (i == 2 || i == 5 || i == 9) x = 2047;
         else if (i == 12) x = -2048;
         else x = rnd_nc();
         step(1, x, 0, 0);
         if (bus.clip) pulses++;
      end
      chk("t2_pulses", 32'(pulses), 4);
      chk("t2_cnt",    32'(bus.clip_cnt), 4);
      chk("t2_ovl",    32'(bus.ovl), 1);
      chk("t2_peak",   32'(bus.peak), 2047);

      // 3: hold release over clean windows
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < WIN; i++) step(1, rnd_nc(), 0, 0);
         chk("t3_ovl", 32'(bus.ovl), (w == 0) ? 1 : 0);
      end

      // 4: sticky set wins over clr
      step(1, -2048, 0, 0);
      step(1, 0, 0, 0);
      step(1, -2048, 0, 0);
      step(1, 0, 1, 0);
      chk("t4_sticky_hold", 32'(bus.sticky), 1);
      step(1, 0, 1, 0);
      chk("t4_sticky_clr", 32'(bus.sticky), 0);
      step(1, 0, 0, 0);

      // 5: gapped valid, every sample clipped
      step(0, 0, 0, 1);
      stbs = 0;
      for (int i = 0; i < 40; i++) begin
         step((i % 2) == 0, rnd_fs(), 0, 0);
         if (bus.peak_stb) stbs++;
      end
      chk("t5_stb", 32'(stbs), 1);
      chk("t5_cnt", 32'(bus.clip_cnt), 16);

      // 6: reset mid-window discards partial clips
      for (int i = 0; i < 8; i++) step(1, rnd_fs(), 0, 0);
      step(1, 0, 0, 1);
      chk("t6_ovl", 32'(bus.ovl), 0);
      for (int i = 0; i < WIN; i++) step(1, rnd_nc(), 0, 0);
      chk("t6_cnt", 32'(bus.clip_cnt), 0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         x = ($urandom_range(0, 3) == 0) ? rnd_fs() : rnd_nc();
         step($urandom_range(0, 3) != 0, x, $urandom_range(0, 7) == 0,
              $urandom_range(0, 499) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
